// File: rtl/vout_pwmgen_pkg.sv
// ============================================================================
// Module      : vout_pkg
// Description : Shared types, defaults and clamp helper for the PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vout_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MIN_PERIOD_DEFAULT = 2;

    // Widest operand the clamp helper accepts; callers cast in and out.
    localparam int CLAMP_W = 64;

    function automatic logic [CLAMP_W-1:0] clamp_min(
        input logic [CLAMP_W-1:0] a,
        input logic [CLAMP_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vout_pwmgen_if.sv
// ============================================================================
// Module      : vout_pwmgen_if
// Description : Register-side controls and pin-side outputs of the PWM
//               generator. DIR exists only when VOUT_PWMGEN_DIR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vout_pwmgen_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] width;
    logic             enable;
    logic             PWM;
    logic             cycle_start;
    logic             active;
`ifdef VOUT_PWMGEN_DIR_EN
    logic             DIR;
`endif

    modport master (
        output period, width, enable,
        input  PWM, cycle_start, active
`ifdef VOUT_PWMGEN_DIR_EN
        , input DIR
`endif
    );

    modport slave (
        input  period, width, enable,
        output PWM, cycle_start, active
`ifdef VOUT_PWMGEN_DIR_EN
        , output DIR
`endif
    );

endinterface

`default_nettype wire

// File: rtl/vout_pwm_shadow.sv
// ============================================================================
// Module      : vout_pwm_shadow
// Description : Double-buffered period/width registers with clamping and
//               load-edge decode. VOUT_PWMGEN_DIR_EN makes width signed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vout_pwm_shadow
    import vout_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             run,
    input  wire logic [WIDTH-1:0] count,
    input  wire logic [WIDTH-1:0] period,
    input  wire logic [WIDTH-1:0] width,
    input  wire logic             enable,
    output logic                  load,
    output logic                  stop,
    output logic      [WIDTH-1:0] period_s,
    output logic      [WIDTH-1:0] width_s,
    output logic      [WIDTH-1:0] width_nx
`ifdef VOUT_PWMGEN_DIR_EN
    , output logic                dir_s
`endif
);

    localparam logic [WIDTH-1:0] c_min_period = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    logic [WIDTH-1:0] w_period_eff;
    logic [WIDTH-1:0] w_mag;
    logic             w_last;
    logic             w_go;

    assign w_period_eff = (period < c_min_period) ? c_min_period : period;

`ifdef VOUT_PWMGEN_DIR_EN
    logic w_neg;
    assign w_neg = width[WIDTH-1];
    // Most negative input negates to itself, which reads as 2^(WIDTH-1) unsigned.
    assign w_mag = w_neg ? (~width + c_one) : width;
`else
    assign w_mag = width;
`endif

    assign width_nx = WIDTH'(clamp_min(CLAMP_W'(w_mag), CLAMP_W'(w_period_eff)));

    assign w_last = run && (count == (period_s - c_one));
    assign w_go   = enable && (period != '0);
    assign load   = (!run || w_last) && w_go;
    assign stop   = w_last && !w_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_s <= '0;
            width_s  <= '0;
`ifdef VOUT_PWMGEN_DIR_EN
            dir_s    <= 1'b0;
`endif
        end else if (load) begin
            period_s <= w_period_eff;
            width_s  <= width_nx;
`ifdef VOUT_PWMGEN_DIR_EN
            dir_s    <= w_neg;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/vout_pwmgen.sv
// ============================================================================
// Module      : vout_pwmgen
// Description : PWM output generator: cycle counter, FSM and registered pin.
//               Optional VOUT_PWMGEN_DIR_EN adds signed width and DIR output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vout_pwmgen
    import vout_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    vout_pwmgen_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_count, w_count_nx, w_count_inc;
    logic             r_pwm, w_pwm_nx;
    logic             r_cycle_start, w_cs_nx;
    logic             w_load, w_stop;
    logic [WIDTH-1:0] w_period_s, w_width_s, w_width_nx;
`ifdef VOUT_PWMGEN_DIR_EN
    logic             w_dir_s;
`endif

    vout_pwm_shadow #(
        .WIDTH      (WIDTH),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (r_state == ST_RUN),
        .count    (r_count),
        .period   (bus.period),
        .width    (bus.width),
        .enable   (bus.enable),
        .load     (w_load),
        .stop     (w_stop),
        .period_s (w_period_s),
        .width_s  (w_width_s),
        .width_nx (w_width_nx)
`ifdef VOUT_PWMGEN_DIR_EN
        , .dir_s  (w_dir_s)
`endif
    );

    assign w_count_inc = r_count + c_one;

    // PWM is computed from the counter value the next clock will hold.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = '0;
        w_pwm_nx   = 1'b0;
        w_cs_nx    = 1'b0;
        if (w_load) begin
            w_state_nx = ST_RUN;
            w_pwm_nx   = (w_width_nx != '0);
            w_cs_nx    = 1'b1;
        end else if (w_stop) begin
            w_state_nx = ST_IDLE;
        end else if (r_state == ST_RUN) begin
            w_count_nx = w_count_inc;
            w_pwm_nx   = (w_count_inc < w_width_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_pwm         <= 1'b0;
            r_cycle_start <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_count       <= w_count_nx;
            r_pwm         <= w_pwm_nx;
            r_cycle_start <= w_cs_nx;
        end
    end

    assign bus.PWM         = r_pwm;
    assign bus.cycle_start = r_cycle_start;
    assign bus.active      = (r_state == ST_RUN);
`ifdef VOUT_PWMGEN_DIR_EN
    assign bus.DIR         = w_dir_s;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vout_pwmgen.sv
// ============================================================================
// Module      : tb_vout_pwmgen
// Description : Directed self-checking bench for vout_pwmgen, including the
//               VOUT_PWMGEN_DIR_EN sequence when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vout_pwmgen;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    // Captured waveforms; the first sample lands in the MSB side so literals read in time order.
    logic [31:0] cap_pwm, cap_cs, cap_act, cap_dir;

    vout_pwmgen_if #(.WIDTH(32)) bus ();

    vout_pwmgen #(
        .WIDTH      (32),
        .MIN_PERIOD (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic capture(input int n);
        cap_pwm = '0;
        cap_cs  = '0;
        cap_act = '0;
        cap_dir = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_pwm = {cap_pwm[30:0], bus.PWM};
            cap_cs  = {cap_cs[30:0],  bus.cycle_start};
            cap_act = {cap_act[30:0], bus.active};
`ifdef VOUT_PWMGEN_DIR_EN
            cap_dir = {cap_dir[30:0], bus.DIR};
`endif
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.period = '0;
        bus.width  = '0;
        bus.enable = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(bus.PWM), 32'd0);
        chk("rst_cs",  32'(bus.cycle_start), 32'd0);
        chk("rst_act", 32'(bus.active), 32'd0);
        rst_n = 1'b1;

        // Nominal: period 10, width 3
        @(negedge clk);
        bus.period = 32'd10;
        bus.width  = 32'd3;
        bus.enable = 1'b1;
        capture(20);
        chk("nom_pwm", cap_pwm, 32'b11100000001110000000);
        chk("nom_cs",  cap_cs,  32'b10000000001000000000);
        chk("nom_act", cap_act, 32'b11111111111111111111);

        // Mid-cycle width change only takes effect at the next cycle
        capture(6);
        chk("mid_cur", cap_pwm, 32'b111000);
        bus.width = 32'd8;
        capture(14);
        chk("mid_nxt", cap_pwm, 32'b00001111111100);

        // width > period clamps to constant high
        bus.width = 32'd15;
        capture(20);
        chk("wclamp_pwm", cap_pwm, 32'b11111111111111111111);
        chk("wclamp_cs",  cap_cs,  32'b10000000001000000000);

        // width 0 gives constant low, cycle_start still pulses
        bus.width = 32'd0;
        capture(20);
        chk("w0_pwm", cap_pwm, 32'b00000000000000000000);
        chk("w0_cs",  cap_cs,  32'b10000000001000000000);

        // period 1 runs as period 2
        bus.period = 32'd1;
        bus.width  = 32'd1;
        capture(8);
        chk("p1_pwm", cap_pwm, 32'b10101010);
        chk("p1_cs",  cap_cs,  32'b10101010);
        bus.width = 32'd5;
        capture(6);
        chk("p1w5_pwm", cap_pwm, 32'b111111);
        chk("p1w5_cs",  cap_cs,  32'b101010);

        // Stop mid-cycle: current cycle completes, then IDLE
        bus.period = 32'd10;
        bus.width  = 32'd6;
        capture(5);
        chk("stop_pre", cap_pwm, 32'b11111);
        bus.enable = 1'b0;
        capture(15);
        chk("stop_pwm", cap_pwm, 32'b100000000000000);
        chk("stop_act", cap_act, 32'b111110000000000);
        chk("stop_cs",  cap_cs,  32'b000000000000000);

        // Restart from IDLE, then async reset during a high phase
        bus.period = 32'd4;
        bus.width  = 32'd2;
        bus.enable = 1'b1;
        capture(1);
        chk("restart_pwm", cap_pwm, 32'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(bus.PWM), 32'd0);
        chk("arst_act", 32'(bus.active), 32'd0);
        @(negedge clk);
        chk("arst_hold", 32'(bus.PWM), 32'd0);
        rst_n = 1'b1;
        capture(8);
        chk("post_pwm", cap_pwm, 32'b11001100);
        chk("post_cs",  cap_cs,  32'b10001000);

`ifdef VOUT_PWMGEN_DIR_EN
        // Signed width: DIR follows the sign, switching only at cycle boundaries
        bus.period = 32'd10;
        bus.width  = 32'hFFFF_FFFC;
        chk("dir_before", 32'(bus.DIR), 32'd0);
        capture(5);
        chk("dir_neg_pwm", cap_pwm, 32'b11110);
        chk("dir_neg_dir", cap_dir, 32'b11111);
        bus.width = 32'd3;
        capture(15);
        chk("dir_pos_pwm", cap_pwm, 32'b000001110000000);
        chk("dir_pos_dir", cap_dir, 32'b111110000000000);
        bus.width = 32'h8000_0000;
        capture(10);
        chk("dir_min_pwm", cap_pwm, 32'b1111111111);
        chk("dir_min_dir", cap_dir, 32'b1111111111);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
